clic_pend_sched: RTL and testbench
==================================

// Module: clic_pend_sched
// PURPOSE
//  Pending-bit scheduler for the n_clic interrupt controller. Synchronises
//  external interrupt lines, detects events, and maintains the desired
//  pended state per vector. Shares the CLIC's single entry-CSR external write
//  port among all sources with a round-robin arbiter and valid/ready handshake.
//  Clears pended on interrupt take. Sits between the external pins and n_clic.
// PARAMETERS
//  VecSize     8        number of interrupt vectors/sources (matches n_clic)
//  VecWidth    derived  $clog2(VecSize), index width
//  SyncStages  2        input synchroniser depth (>=2)
//  EdgeMask    '1       VecSize bits; 1 = rising-edge source, 0 = level source
// PORTS
//  clk        in   1         core clock
//  reset      in   1         asynchronous, active-low reset
//  irq_in     in   VecSize   raw asynchronous interrupt lines
//  take_valid in   1         n_clic took an interrupt this cycle
//  take_vec   in   VecWidth  index of the taken vector
//  wr_ready   in   1         entry-CSR ext write port accepts this cycle
//  wr_valid   out  1         write request to entry CSR pended bit
//  wr_idx     out  VecWidth  entry index being written
//  wr_pend    out  1         value to write into the pended bit
//  pending    out  VecSize   desired pended state per source (want[])
//  overflow   out  VecSize   sticky: edge lost while already pending
// BEHAVIOUR
//  Reset (reset=0, async): wr_valid=0, wr_idx=0, wr_pend=0, pending=0,
//   overflow=0; sync flops, dirty[], rr_ptr=0, FSM=IDLE. Asserting reset
//   mid-handshake drops wr_valid immediately; the write is abandoned.
//  Sync: irq_in through SyncStages flops -> s[i]; s_d = s delayed one cycle.
//  Events (per i, per cycle):
//   edge src: set_i = s[i] & ~s_d[i]; clr_i = take_valid & take_vec==i.
//    set_i -> want=1, dirty=1; else clr_i -> want=0, dirty=1.
//    set_i & clr_i same cycle: set wins (want=1, dirty=1).
//   level src: want follows s[i]; dirty=1 whenever s[i] != want.
//    take_valid on a level source is ignored.
//  take_vec >= VecSize: ignored.
//  FSM: IDLE -> ISSUE when any dirty=1; grant = first dirty index
//   scanning rr_ptr, rr_ptr+1, ... wrapping modulo VecSize. On entering
//   ISSUE, register wr_valid=1, wr_idx=grant, wr_pend=want[grant].
//   ISSUE: wr_idx/wr_pend held stable until wr_ready=1 (sampled at clk).
//   On accept: wr_valid=0, rr_ptr=(wr_idx+1) mod VecSize, FSM=IDLE;
//    dirty[wr_idx] cleared only if want[wr_idx]==wr_pend and no event on
//    wr_idx in that cycle; otherwise stays set and is reissued later.
//  Throughput: one write per 2 cycles (IDLE/ISSUE) with wr_ready tied 1.
//  Latency: irq_in rise -> wr_valid = SyncStages+2 cycles (idle, wr_ready=1).
//  Fairness: a continuously dirty source waits at most VecSize grants.
//  Overflow (feature below): edge on i while want[i]=1 sets overflow[i].
// CONFIGURATION
//  CLIC_PEND_OVF_EN defined: overflow[] tracked, sticky until reset.
//  CLIC_PEND_OVF_EN undefined: overflow tied to 0, no tracking flops built;
//   all other behaviour identical.
// TESTING
//  1 reset low 3 cycles, release -> all outputs 0, wr_valid stays 0 idle.
//  2 irq_in[3] 0->1, wr_ready=1 -> wr_valid at cycle SyncStages+2,
//    wr_idx=3, wr_pend=1; pending=8'h08.
//  3 edges on src 1,5,6 same cycle, rr_ptr=0, wr_ready=1 -> grants 1,5,6
//    in order; next edge on 1 and 2 after rr_ptr=7 -> grants 1 then 2.
//  4 wr_ready=0 for 5 cycles with wr_idx=2 pending -> wr_valid/wr_idx/wr_pend
//    stable; take_valid,take_vec=2 during stall -> after accept of 1,
//    reissue idx 2 with wr_pend=0.
//  5 take_valid & edge on src 4 same cycle -> pending[4]=1, write pend=1.
//  6 OVF_EN: two edges on src 0 before take -> overflow=8'h01; undefined -> 0.

Source files
------------

// File: rtl/clic_pend_sched.sv
// Pending-bit scheduler for n_clic: synchronises irq lines, tracks desired pended state,
// and shares the single entry-CSR write port round-robin. Optional overflow tracking: CLIC_PEND_OVF_EN.
module clic_pend_sched #(
  parameter int unsigned        VecSize    = 8,
  parameter int unsigned        VecWidth   = (VecSize > 1) ? $clog2(VecSize) : 1,
  parameter int unsigned        SyncStages = 2,
  parameter logic [VecSize-1:0] EdgeMask   = '1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [VecSize-1:0]  irq_in_i,
  input  logic                take_valid_i,
  input  logic [VecWidth-1:0] take_vec_i,
  input  logic                wr_ready_i,
  output logic                wr_valid_o,
  output logic [VecWidth-1:0] wr_idx_o,
  output logic                wr_pend_o,
  output logic [VecSize-1:0]  pending_o,
  output logic [VecSize-1:0]  overflow_o
);

  typedef enum logic {IDLE, ISSUE} state_e;

  logic [SyncStages-1:0][VecSize-1:0] sync_q;
  logic [VecSize-1:0]  s, sd_q;
  logic [VecSize-1:0]  take_hit, set_ev, clr_ev, ev;
  logic [VecSize-1:0]  want_q, want_d, dirty_q, dirty_d;
  state_e              state_q, state_d;
  logic [VecWidth-1:0] idx_q, idx_d, rr_q, rr_d, grant;
  logic                pend_q, pend_d;

  function automatic logic [VecWidth-1:0] rr_pick(input logic [VecSize-1:0] req,
                                                  input logic [VecWidth-1:0] ptr);
    logic [VecWidth-1:0] pick;
    logic                found;
    int unsigned         idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < VecSize; k++) begin
      idx = (32'(ptr) + k) % VecSize;
      if (!found && req[idx]) begin
        pick  = VecWidth'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      sd_q   <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], irq_in_i};
      sd_q   <= s;
    end
  end

  assign s = sync_q[SyncStages-1];

  // Out-of-range take_vec shifts past the top bit and therefore hits nothing.
  always_comb begin
    take_hit = take_valid_i ? (VecSize'(1) << take_vec_i) : '0;
    set_ev   = EdgeMask & s & ~sd_q;
    clr_ev   = EdgeMask & take_hit & ~set_ev;
    ev       = (EdgeMask & (set_ev | take_hit)) | (~EdgeMask & (s ^ want_q));
    want_d   = (EdgeMask & ((want_q | set_ev) & ~clr_ev)) | (~EdgeMask & s);
    grant    = rr_pick(dirty_q, rr_q);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    rr_d    = rr_q;
    dirty_d = dirty_q | ev;
    case (state_q)
      IDLE: begin
        if (|dirty_q) begin
          state_d = ISSUE;
          idx_d   = grant;
          pend_d  = want_q[grant];
        end
      end
      ISSUE: begin
        if (wr_ready_i) begin
          state_d = IDLE;
          rr_d    = (idx_q == VecWidth'(VecSize - 1)) ? '0 : idx_q + 1'b1;
          // A write that raced a fresh event must be reissued with the new value.
          if (want_q[idx_q] == pend_q && !ev[idx_q]) dirty_d[idx_q] = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      rr_q    <= '0;
      want_q  <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      want_q  <= want_d;
      dirty_q <= dirty_d;
    end
  end

`ifdef CLIC_PEND_OVF_EN
  logic [VecSize-1:0] ovf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ovf_q <= '0;
    else         ovf_q <= ovf_q | (set_ev & want_q);
  end

  assign overflow_o = ovf_q;
`else
  assign overflow_o = '0;
`endif

  assign wr_valid_o = (state_q == ISSUE);
  assign wr_idx_o   = idx_q;
  assign wr_pend_o  = pend_q;
  assign pending_o  = want_q;

endmodule

// File: tb/tb_clic_pend_sched.sv
// Directed and randomized bench for clic_pend_sched against a per-source behavioural model.
module tb_clic_pend_sched;

  localparam int N = 8;
  localparam int W = 3;
  localparam int S = 2;
  localparam logic [N-1:0] EDGE = 8'h7F;
`ifdef CLIC_PEND_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] irq_in;
  logic         take_valid;
  logic [W-1:0] take_vec;
  logic         wr_ready;
  logic         wr_valid;
  logic [W-1:0] wr_idx;
  logic         wr_pend;
  logic [N-1:0] pending;
  logic [N-1:0] overflow;

  clic_pend_sched #(.VecSize(N), .SyncStages(S), .EdgeMask(EDGE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .irq_in_i(irq_in), .take_valid_i(take_valid),
    .take_vec_i(take_vec), .wr_ready_i(wr_ready), .wr_valid_o(wr_valid),
    .wr_idx_o(wr_idx), .wr_pend_o(wr_pend), .pending_o(pending), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference state: per-source desired value, outstanding-write flags, one write slot.
  logic [N-1:0] pipe[$];
  logic [N-1:0] m_want, m_dirty, m_ovf;
  bit           m_busy, m_pend;
  int           m_idx, m_rr;
  int           grants[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i <= S; i++) pipe.push_back('0);
    m_want = '0; m_dirty = '0; m_ovf = '0;
    m_busy = 1'b0; m_pend = 1'b0; m_idx = 0; m_rr = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] s, sd, wn, ev;
    int g, idx;
    s = pipe[S-1]; sd = pipe[S]; wn = m_want; ev = '0;
    for (int i = 0; i < N; i++) begin
      if (EDGE[i]) begin
        if (s[i] && !sd[i]) begin
          wn[i] = 1'b1; ev[i] = 1'b1;
          if (m_want[i] && OVF) m_ovf[i] = 1'b1;
        end else if (take_valid && int'(take_vec) == i) begin
          wn[i] = 1'b0; ev[i] = 1'b1;
        end
      end else if (s[i] != m_want[i]) begin
        wn[i] = s[i]; ev[i] = 1'b1;
      end
    end
    if (m_busy) begin
      if (wr_ready) begin
        m_busy = 1'b0;
        m_rr = (m_idx + 1) % N;
        if (m_want[m_idx] == m_pend && !ev[m_idx]) m_dirty[m_idx] = 1'b0;
      end
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (g < 0 && m_dirty[idx]) g = idx;
      end
      if (g >= 0) begin
        m_busy = 1'b1; m_idx = g; m_pend = m_want[g];
      end
    end
    m_dirty = m_dirty | ev;
    m_want = wn;
    pipe.push_front(irq_in);
    void'(pipe.pop_back());
  endtask

  task automatic check_all();
    chk("wr_valid", 32'(wr_valid), 32'(m_busy));
    chk("wr_idx",   32'(wr_idx),   m_idx);
    chk("wr_pend",  32'(wr_pend),  32'(m_pend));
    chk("pending",  32'(pending),  32'(m_want));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic collect(int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      if (wr_valid && wr_ready) grants.push_back(int'(wr_idx));
      cyc();
    end
  endtask

  task automatic wait_valid(string tag);
    int n = 0;
    while (!wr_valid && n < 20) begin
      cyc();
      n++;
    end
    chk(tag, 32'(wr_valid), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; irq_in = '0; take_valid = 1'b0; take_vec = '0; wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_valid", 32'(wr_valid), 0);
    chk("rst_wr_idx",   32'(wr_idx),   0);
    chk("rst_wr_pend",  32'(wr_pend),  0);
    chk("rst_pending",  32'(pending),  0);
    chk("rst_overflow", 32'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int lat;
    int e3a[3] = '{1, 5, 6};
    int e3b[2] = '{1, 2};

    // Reset and idle
    do_reset();
    repeat (4) cyc();
    chk("idle_wr_valid", 32'(wr_valid), 0);

    // Single edge latency
    irq_in = 8'h08;
    lat = 0;
    while (!wr_valid && lat < 12) begin
      cyc();
      lat++;
    end
    chk("t2_latency", lat, S + 2);
    chk("t2_idx",     32'(wr_idx), 3);
    chk("t2_pend",    32'(wr_pend), 1);
    chk("t2_pending", 32'(pending), 32'h08);
    repeat (3) cyc();

    // Round-robin order from rr_ptr=0, then wrap from rr_ptr=7
    do_reset();
    irq_in = 8'h62;
    grants.delete();
    collect(14);
    chk("t3a_count", grants.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("t3a_grant%0d", i), grants[i], e3a[i]);
    irq_in = '0;
    repeat (4) cyc();
    irq_in = 8'h06;
    grants.delete();
    collect(12);
    chk("t3b_count", grants.size(), 2);
    for (int i = 0; i < 2; i++) chk($sformatf("t3b_grant%0d", i), grants[i], e3b[i]);

    // Stall with take on the stalled index, then reissue with pend=0
    irq_in = '0;
    repeat (4) cyc();
    wr_ready = 1'b0;
    irq_in = 8'h04;
    wait_valid("t4_valid");
    chk("t4_idx", 32'(wr_idx), 2);
    chk("t4_pend", 32'(wr_pend), 1);
    for (int j = 0; j < 5; j++) begin
      take_valid = (j == 2);
      take_vec = 3'd2;
      cyc();
      chk("t4_stall_valid", 32'(wr_valid), 1);
      chk("t4_stall_idx", 32'(wr_idx), 2);
      chk("t4_stall_pend", 32'(wr_pend), 1);
    end
    take_valid = 1'b0;
    wr_ready = 1'b1;
    cyc();
    wait_valid("t4_revalid");
    chk("t4_re_idx", 32'(wr_idx), 2);
    chk("t4_re_pend", 32'(wr_pend), 0);
    cyc();

    // Take and edge on the same source in the same cycle
    irq_in = 8'h14;
    cyc();
    cyc();
    take_valid = 1'b1;
    take_vec = 3'd4;
    cyc();
    take_valid = 1'b0;
    chk("t5_pending4", 32'(pending[4]), 1);
    wait_valid("t5_valid");
    chk("t5_idx", 32'(wr_idx), 4);
    chk("t5_pend", 32'(wr_pend), 1);
    cyc();

    // Two edges on source 0 before any take
    irq_in = 8'h15;
    repeat (6) cyc();
    irq_in = 8'h14;
    repeat (3) cyc();
    irq_in = 8'h15;
    repeat (6) cyc();
    chk("t6_ovf0", 32'(overflow[0]), 32'(OVF));

    // Reset asserted mid-handshake drops wr_valid at once
    wr_ready = 1'b0;
    irq_in = 8'h35;
    wait_valid("t7_valid");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_async_valid", 32'(wr_valid), 0);
    chk("t7_async_pending", 32'(pending), 0);
    do_reset();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) irq_in[$urandom_range(0, N - 1)] ^= 1'b1;
      take_valid = ($urandom_range(0, 5) == 0);
      take_vec   = W'($urandom_range(0, N - 1));
      wr_ready   = ($urandom_range(0, 2) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
